// File: rtl/io_input_cond_pkg.sv
// Shared sizing constants for the board input conditioning stage.
package io_pkg;
  localparam int IO_SW_WIDTH        = 32;
  localparam int IO_BTN_WIDTH       = 4;
  localparam int IO_DEBOUNCE_CYCLES = 500_000;

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/io_input_cond_if.sv
// Raw board pins in, debounced levels and event strobes out.
interface io_input_cond_if #(
  parameter int SW_WIDTH  = io_pkg::IO_SW_WIDTH,
  parameter int BTN_WIDTH = io_pkg::IO_BTN_WIDTH
);
  logic [SW_WIDTH-1:0]  sw_raw_i;
  logic [BTN_WIDTH-1:0] btn_raw_i;
  logic [SW_WIDTH-1:0]  io_sw_o;
  logic [BTN_WIDTH-1:0] io_btn_o;
  logic [BTN_WIDTH-1:0] btn_press_o;
  logic                 sw_change_o;

  modport master (
    output sw_raw_i, btn_raw_i,
    input  io_sw_o, io_btn_o, btn_press_o, sw_change_o
  );

  modport slave (
    input  sw_raw_i, btn_raw_i,
    output io_sw_o, io_btn_o, btn_press_o, sw_change_o
  );
endinterface

// File: rtl/io_input_cond_debounce_bit.sv
// One button: synchroniser, stable-time counter, stable level and press strobe.
module debounce_bit import io_pkg::*; #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES,
  parameter bit IDLE            = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o,
  output logic press_o
);
  localparam int            CW      = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= {SYNC_STAGES{IDLE}};
      cnt_q    <= '0;
      stable_o <= IDLE;
      press_o  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      press_o <= 1'b0;
      if (s == stable_o) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        // Any level other than the idle (released) level is a press.
        stable_o <= s;
        cnt_q    <= '0;
        press_o  <= (s != IDLE);
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: rtl/io_input_cond.sv
// Synchronises and debounces board switches and buttons for the LSU input region.
module io_input_cond import io_pkg::*; #(
  parameter int SW_WIDTH        = IO_SW_WIDTH,
  parameter int BTN_WIDTH       = IO_BTN_WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  io_input_cond_if.slave  io
);
  localparam int            CW         = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] SW_LOAD_AT = CW'(DEBOUNCE_CYCLES - 2);

  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync_q;
  logic [SW_WIDTH-1:0]                  sw_s;
  logic [SW_WIDTH-1:0]                  sw_prev_q;
  logic [SW_WIDTH-1:0]                  sw_stable_q;
  logic [CW-1:0]                        sw_cnt_q;
  logic                                 sw_chg_q;
  logic [BTN_WIDTH-1:0]                 btn_stable;
  logic [BTN_WIDTH-1:0]                 btn_press;

  assign sw_s = sw_sync_q[SYNC_STAGES-1];

  // The edge that sees a new switch word clears the count, so loading as the
  // count would reach D-1 accepts a value held for D edges including that one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_sync_q   <= '0;
      sw_prev_q   <= '0;
      sw_stable_q <= '0;
      sw_cnt_q    <= '0;
      sw_chg_q    <= 1'b0;
    end else begin
      sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], io.sw_raw_i};
      sw_prev_q <= sw_s;
      sw_chg_q  <= 1'b0;
      if ((sw_s != sw_prev_q) || (sw_s == sw_stable_q)) begin
        sw_cnt_q <= '0;
      end else if (sw_cnt_q == SW_LOAD_AT) begin
        sw_stable_q <= sw_s;
        sw_cnt_q    <= '0;
        sw_chg_q    <= 1'b1;
      end else begin
        sw_cnt_q <= sw_cnt_q + CW'(1);
      end
    end
  end

  for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE            (BTN_ACTIVE_LOW)
    ) u_db (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .raw_i    (io.btn_raw_i[i]),
      .stable_o (btn_stable[i]),
      .press_o  (btn_press[i])
    );
  end

  assign io.io_sw_o     = sw_stable_q;
  assign io.sw_change_o = sw_chg_q;
  assign io.io_btn_o    = btn_stable;
  assign io.btn_press_o = btn_press;
endmodule

// File: tb/tb_io_input_cond.sv
// Bench for io_input_cond with D=8, two sync stages, active-low buttons.
module tb_io_input_cond;
  localparam int D = 8;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  io_input_cond_if #(.SW_WIDTH(32), .BTN_WIDTH(4)) bus ();

  io_input_cond #(
    .SW_WIDTH        (32),
    .BTN_WIDTH       (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (D),
    .BTN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: raw history per edge; an output adopts a value once the
  // synchronised input (raw two edges back) has shown it for D edges in a row.
  logic [31:0] sh [D+1];
  logic [3:0]  bh [D+1];
  logic [31:0] m_sw;
  logic [3:0]  m_btn, m_press, btn_flip;
  logic        m_chg, sw_win_ok;

  always_comb begin
    sw_win_ok = 1'b1;
    for (int k = 2; k <= D; k++) if (sh[k] !== sh[1]) sw_win_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      btn_flip[i] = 1'b1;
      for (int k = 1; k <= D; k++) if (bh[k][i] === m_btn[i]) btn_flip[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= D; k++) begin
        sh[k] <= '0;
        bh[k] <= 4'hF;
      end
      m_sw <= '0; m_btn <= 4'hF; m_press <= '0; m_chg <= 1'b0;
    end else begin
      for (int k = D; k > 0; k--) begin
        sh[k] <= sh[k-1];
        bh[k] <= bh[k-1];
      end
      sh[0] <= bus.sw_raw_i;
      bh[0] <= bus.btn_raw_i;
      if (sw_win_ok && (sh[1] !== m_sw)) begin
        m_sw  <= sh[1];
        m_chg <= 1'b1;
      end else begin
        m_chg <= 1'b0;
      end
      m_btn   <= m_btn ^ btn_flip;
      m_press <= btn_flip & m_btn;
    end
  end

  wire [40:0] obs   = {bus.io_sw_o, bus.io_btn_o, bus.btn_press_o, bus.sw_change_o};
  wire [40:0] exp_v = {m_sw, m_btn, m_press, m_chg};

  task automatic test_reset();
    rst = 1'b1;
    bus.sw_raw_i  = 32'hA5A5_A5A5;
    bus.btn_raw_i = 4'hF;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.io_sw_o === 32'h0 && bus.io_btn_o === 4'hF && bus.btn_press_o === 4'h0 && bus.sw_change_o === 1'b0)
      n_pass++;
    else
      $display("FAIL reset_state: got sw=%h btn=%h press=%b chg=%b want sw=0 btn=f press=0 chg=0",
               bus.io_sw_o, bus.io_btn_o, bus.btn_press_o, bus.sw_change_o);
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      n_chk++;
      if (bus.io_sw_o === ((e >= 10) ? 32'hA5A5_A5A5 : 32'h0) && bus.sw_change_o === (e == 10) &&
          bus.btn_press_o === 4'h0 && obs === exp_v)
        n_pass++;
      else
        $display("FAIL reset_release e=%0d: got sw=%h chg=%b press=%b (all %h) want sw=%h chg=%b press=0 (model %h)",
                 e, bus.io_sw_o, bus.sw_change_o, bus.btn_press_o, obs,
                 (e >= 10) ? 32'hA5A5_A5A5 : 32'h0, (e == 10), exp_v);
    end
  endtask

  task automatic test_clean_press();
    bus.btn_raw_i = 4'hB;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      n_chk++;
      if (bus.io_btn_o === ((e >= 10) ? 4'hB : 4'hF) && bus.btn_press_o === ((e == 10) ? 4'b0100 : 4'b0000) &&
          obs === exp_v)
        n_pass++;
      else
        $display("FAIL clean_press e=%0d: got btn=%h press=%b (all %h) want btn=%h press=%b (model %h)",
                 e, bus.io_btn_o, bus.btn_press_o, obs, (e >= 10) ? 4'hB : 4'hF,
                 (e == 10) ? 4'b0100 : 4'b0000, exp_v);
    end
    bus.btn_raw_i = 4'hF;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      n_chk++;
      if (bus.io_btn_o === ((e >= 10) ? 4'hF : 4'hB) && bus.btn_press_o === 4'h0 && obs === exp_v)
        n_pass++;
      else
        $display("FAIL clean_release e=%0d: got btn=%h press=%b want btn=%h press=0 (model %h)",
                 e, bus.io_btn_o, bus.btn_press_o, (e >= 10) ? 4'hF : 4'hB, exp_v);
    end
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 8; c++) begin
      bus.btn_raw_i = (c < 7) ? 4'hE : 4'hF;
      @(negedge clk);
      n_chk++;
      if (bus.io_btn_o === 4'hF && bus.btn_press_o === 4'h0 && obs === exp_v)
        n_pass++;
      else
        $display("FAIL bounce_hold c=%0d: got btn=%h press=%b want btn=f press=0 (model %h)",
                 c, bus.io_btn_o, bus.btn_press_o, exp_v);
    end
    bus.btn_raw_i = 4'hE;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      n_chk++;
      if (bus.io_btn_o === ((e >= 10) ? 4'hE : 4'hF) && bus.btn_press_o === ((e == 10) ? 4'b0001 : 4'b0000) &&
          obs === exp_v)
        n_pass++;
      else
        $display("FAIL bounce_settle e=%0d: got btn=%h press=%b want btn=%h press=%b (model %h)",
                 e, bus.io_btn_o, bus.btn_press_o, (e >= 10) ? 4'hE : 4'hF,
                 (e == 10) ? 4'b0001 : 4'b0000, exp_v);
    end
    bus.btn_raw_i = 4'hF;
    repeat (12) begin
      @(negedge clk);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL bounce_release: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_sw_ripple();
    bus.sw_raw_i = 32'h0;
    repeat (12) begin
      @(negedge clk);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL sw_clear: got %h want %h", obs, exp_v);
    end
    for (int s = 0; s < 2; s++) begin
      bus.sw_raw_i = (s == 0) ? 32'h1 : 32'h3;
      @(negedge clk);
      n_chk++;
      if (bus.io_sw_o === 32'h0 && obs === exp_v) n_pass++;
      else $display("FAIL sw_ripple_step s=%0d: got sw=%h want sw=0 (model %h)", s, bus.io_sw_o, exp_v);
    end
    bus.sw_raw_i = 32'h7;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      n_chk++;
      if (bus.io_sw_o === ((e >= 10) ? 32'h7 : 32'h0) && bus.sw_change_o === (e == 10) && obs === exp_v)
        n_pass++;
      else
        $display("FAIL sw_ripple e=%0d: got sw=%h chg=%b want sw=%h chg=%b (model %h)",
                 e, bus.io_sw_o, bus.sw_change_o, (e >= 10) ? 32'h7 : 32'h0, (e == 10), exp_v);
    end
  endtask

  task automatic test_simul_reset();
    bus.btn_raw_i = 4'h5;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      n_chk++;
      if (bus.io_btn_o === ((e >= 10) ? 4'h5 : 4'hF) && bus.btn_press_o === ((e == 10) ? 4'b1010 : 4'b0000) &&
          obs === exp_v)
        n_pass++;
      else
        $display("FAIL simul_press e=%0d: got btn=%h press=%b want btn=%h press=%b (model %h)",
                 e, bus.io_btn_o, bus.btn_press_o, (e >= 10) ? 4'h5 : 4'hF,
                 (e == 10) ? 4'b1010 : 4'b0000, exp_v);
    end
    bus.btn_raw_i = 4'hF;
    repeat (12) begin
      @(negedge clk);
      n_chk++;
      if (bus.btn_press_o === 4'h0 && obs === exp_v) n_pass++;
      else $display("FAIL simul_release: got %h want %h", obs, exp_v);
    end
    bus.btn_raw_i = 4'hE;
    repeat (7) begin
      @(negedge clk);
      n_chk++;
      if (bus.io_btn_o === 4'hF && bus.btn_press_o === 4'h0 && obs === exp_v) n_pass++;
      else $display("FAIL midcount_pre: got btn=%h press=%b want btn=f press=0", bus.io_btn_o, bus.btn_press_o);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.io_btn_o === 4'hF && bus.io_sw_o === 32'h0 && bus.btn_press_o === 4'h0 && bus.sw_change_o === 1'b0)
      n_pass++;
    else
      $display("FAIL midcount_reset: got sw=%h btn=%h press=%b chg=%b want sw=0 btn=f press=0 chg=0",
               bus.io_sw_o, bus.io_btn_o, bus.btn_press_o, bus.sw_change_o);
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      n_chk++;
      if (bus.io_btn_o === ((e >= 10) ? 4'hE : 4'hF) && bus.btn_press_o === ((e == 10) ? 4'b0001 : 4'b0000) &&
          obs === exp_v)
        n_pass++;
      else
        $display("FAIL midcount_after e=%0d: got btn=%h press=%b want btn=%h press=%b (model %h)",
                 e, bus.io_btn_o, bus.btn_press_o, (e >= 10) ? 4'hE : 4'hF,
                 (e == 10) ? 4'b0001 : 4'b0000, exp_v);
    end
    bus.btn_raw_i = 4'hF;
    repeat (12) begin
      @(negedge clk);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL midcount_release: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_random();
    int mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) mode = $urandom_range(0, 4);
      rst = ($urandom_range(0, 599) == 0);
      if (mode == 1)
        bus.btn_raw_i = bus.btn_raw_i ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      else if (mode == 2 && $urandom_range(0, 3) == 0)
        bus.sw_raw_i = bus.sw_raw_i ^ (32'd1 << $urandom_range(0, 31));
      else if (mode == 3 && $urandom_range(0, 9) == 0) begin
        bus.btn_raw_i = 4'($urandom_range(0, 15));
        bus.sw_raw_i  = $urandom;
      end
      @(negedge clk);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL random c=%0d: got sw=%h btn=%h press=%b chg=%b want sw=%h btn=%h press=%b chg=%b",
                    c, bus.io_sw_o, bus.io_btn_o, bus.btn_press_o, bus.sw_change_o,
                    m_sw, m_btn, m_press, m_chg);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_sw_ripple();
    test_simul_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
